// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: issues in-order program reads and buffers returned instructions in a 2-entry FIFO.
module instr_fetch_unit #(
    parameter int ADDR_W  = 5,
    parameter int INSTR_W = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [ADDR_W-1:0]  pc_val,
    output logic               pc_inc,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_gnt,
    input  logic               mem_rvalid,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    input  logic               instr_ready,
    input  logic               flush
);
    typedef enum logic {RUN, DRAIN} state_t;
    state_t             state;
    logic [INSTR_W-1:0] buf_q [2];
    logic               rd_ptr, wr_ptr, rv, push, pop;
    logic [1:0]         count, outstanding, drop_cnt, net;
    always_comb begin
        mem_req     = rstn && state == RUN && (3'(count) + 3'(outstanding) < 3'd2) && !flush;
        mem_addr    = pc_val;
        pc_inc      = mem_req && mem_gnt;
        instr_valid = count != 2'd0;
        instr       = instr_valid ? buf_q[rd_ptr] : '0;
        // responses arriving with nothing in flight are stale and ignored
        rv          = mem_rvalid && outstanding != 2'd0;
        net         = outstanding - 2'(rv);
        pop         = instr_valid && instr_ready;
        push        = rv && state == RUN && !flush;
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= RUN;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            buf_q[0]    <= '0;
            buf_q[1]    <= '0;
        end else begin
            outstanding <= outstanding + 2'(pc_inc) - 2'(rv);
            if (push)
                buf_q[wr_ptr] <= mem_rdata;
            if (state == DRAIN) begin
                if (rv)
                    drop_cnt <= drop_cnt - 2'd1;
                if (rv && drop_cnt == 2'd1)
                    state <= RUN;
            end else if (flush) begin
                count    <= '0;
                rd_ptr   <= 1'b0;
                wr_ptr   <= 1'b0;
                drop_cnt <= net;
                if (net != 2'd0)
                    state <= DRAIN;
            end else begin
                count <= count + 2'(push) - 2'(pop);
                if (push)
                    wr_ptr <= ~wr_ptr;
                if (pop)
                    rd_ptr <= ~rd_ptr;
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized and directed checks against a queue-based model of the fetch unit.
module tb_instr_fetch_unit;
    logic       clk, rstn, pc_inc, mem_req, mem_gnt, mem_rvalid, instr_valid, instr_ready, flush;
    logic [4:0] pc_val, mem_addr;
    logic [7:0] mem_rdata, instr;

    instr_fetch_unit #(.ADDR_W(5), .INSTR_W(8)) dut (
        .clk(clk), .rstn(rstn), .pc_val(pc_val), .pc_inc(pc_inc), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready), .flush(flush)
    );

    typedef struct {logic [4:0] addr; bit kill;} req_t;
    req_t        infl[$];
    logic [7:0]  q[$];
    logic [7:0]  rom[32];
    logic [4:0]  pc;
    logic        e_req;
    logic [15:0] e_vec;
    int          vectors, miscompares;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // expectations come from the queues: a flush kills every in-flight request, and
    // no new request is made while a killed one is still pending
    task automatic apply(input logic g, input logic rv, input logic r, input logic f, input logic [4:0] npc);
        if (f) pc = npc;
        pc_val      = pc;
        mem_gnt     = g;
        mem_rvalid  = rv;
        instr_ready = r;
        flush       = f;
        mem_rdata   = infl.size() > 0 ? rom[infl[0].addr] : 8'($urandom);
        e_req = rstn && !(infl.size() > 0 && infl[0].kill) && (q.size() + infl.size() < 2) && !f;
        e_vec = {e_req, e_req & g, pc, q.size() > 0, q.size() > 0 ? q[0] : 8'h00};
        #1;
    endtask

    task automatic advance();
        bit   rvv;
        req_t e;
        rvv = mem_rvalid && infl.size() > 0;
        if (flush) begin
            q.delete();
            if (rvv) void'(infl.pop_front());
            foreach (infl[i]) infl[i].kill = 1'b1;
        end else begin
            if (q.size() > 0 && instr_ready) void'(q.pop_front());
            if (rvv) begin
                e = infl.pop_front();
                if (!e.kill) q.push_back(rom[e.addr]);
            end
            if (e_req && mem_gnt) begin
                e.addr = pc;
                e.kill = 1'b0;
                infl.push_back(e);
                pc = pc + 5'd1;
            end
        end
        @(negedge clk);
    endtask

    task automatic settle();
        for (int i = 0; i < 6; i++) begin
            apply(1'b0, infl.size() > 0, 1'b1, 1'b0, pc);
            advance();
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        pc = 5'd0;
        apply(1'b1, 1'b0, 1'b1, 1'b0, pc);
        @(negedge clk);
        vectors++;
        if ({mem_req, pc_inc, mem_addr, instr_valid, instr} !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset: got %h exp %h", {mem_req, pc_inc, mem_addr, instr_valid, instr}, 16'h0000);
        end
        rstn = 1'b1;
        apply(1'b0, 1'b0, 1'b1, 1'b0, pc);
        vectors++;
        if ({mem_req, pc_inc, mem_addr, instr_valid, instr} !== e_vec) begin
            miscompares++;
            $display("FAIL reset_release: got %h exp %h", {mem_req, pc_inc, mem_addr, instr_valid, instr}, e_vec);
        end
        advance();
    endtask

    task automatic test_stream();
        for (int i = 0; i < 32; i++) rom[i] = 8'(i + 16);
        for (int c = 0; c < 60; c++) begin
            apply(1'b1, infl.size() > 0, 1'b1, 1'b0, pc);
            vectors++;
            if ({mem_req, pc_inc, mem_addr, instr_valid, instr} !== e_vec) begin
                miscompares++;
                $display("FAIL stream c%0d: got %h exp %h", c, {mem_req, pc_inc, mem_addr, instr_valid, instr}, e_vec);
            end
            advance();
        end
    endtask

    task automatic test_stall();
        settle();
        for (int c = 0; c < 10; c++) begin
            apply(1'b1, infl.size() > 0, c >= 5, 1'b0, pc);
            vectors++;
            if ({mem_req, pc_inc, mem_addr, instr_valid, instr} !== e_vec) begin
                miscompares++;
                $display("FAIL stall c%0d: got %h exp %h", c, {mem_req, pc_inc, mem_addr, instr_valid, instr}, e_vec);
            end
            advance();
        end
    endtask

    task automatic test_gnt_delay();
        settle();
        for (int c = 0; c < 5; c++) begin
            apply(c == 3, infl.size() > 0, 1'b1, 1'b0, pc);
            vectors++;
            if ({mem_req, pc_inc, mem_addr, instr_valid, instr} !== e_vec) begin
                miscompares++;
                $display("FAIL gnt_delay c%0d: got %h exp %h", c, {mem_req, pc_inc, mem_addr, instr_valid, instr}, e_vec);
            end
            advance();
        end
    endtask

    task automatic test_flush();
        settle();
        for (int c = 0; c < 8; c++) begin
            apply(c < 2, c > 2 && infl.size() > 0, 1'b1, c == 2, 5'd7);
            vectors++;
            if ({mem_req, pc_inc, mem_addr, instr_valid, instr} !== e_vec) begin
                miscompares++;
                $display("FAIL flush c%0d: got %h exp %h", c, {mem_req, pc_inc, mem_addr, instr_valid, instr}, e_vec);
            end
            advance();
        end
    endtask

    task automatic test_flush_pop_rvalid();
        settle();
        for (int c = 0; c < 5; c++) begin
            apply(c < 2, c >= 1 && infl.size() > 0, c >= 2, c == 2, 5'd20);
            vectors++;
            if ({mem_req, pc_inc, mem_addr, instr_valid, instr} !== e_vec) begin
                miscompares++;
                $display("FAIL flush_pop_rv c%0d: got %h exp %h", c, {mem_req, pc_inc, mem_addr, instr_valid, instr}, e_vec);
            end
            advance();
        end
    endtask

    task automatic test_reset_midflight();
        settle();
        apply(1'b1, 1'b0, 1'b1, 1'b0, pc);
        advance();
        rstn = 1'b0;
        q.delete();
        infl.delete();
        #1;
        vectors++;
        if ({mem_req, pc_inc, instr_valid, instr} !== 11'h000) begin
            miscompares++;
            $display("FAIL mid_reset: got %h exp %h", {mem_req, pc_inc, instr_valid, instr}, 11'h000);
        end
        @(negedge clk);
        rstn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            apply(1'b0, c == 0, 1'b1, 1'b0, pc);
            vectors++;
            if ({mem_req, pc_inc, mem_addr, instr_valid, instr} !== e_vec) begin
                miscompares++;
                $display("FAIL stray_rvalid c%0d: got %h exp %h", c, {mem_req, pc_inc, mem_addr, instr_valid, instr}, e_vec);
            end
            advance();
        end
    endtask

    task automatic test_random();
        settle();
        for (int i = 0; i < 32; i++) rom[i] = 8'($urandom);
        for (int c = 0; c < 400; c++) begin
            apply($urandom % 4 != 0, infl.size() > 0 && $urandom % 2 == 0, $urandom % 3 != 0,
                  $urandom % 12 == 0, 5'($urandom));
            vectors++;
            if ({mem_req, pc_inc, mem_addr, instr_valid, instr} !== e_vec) begin
                miscompares++;
                $display("FAIL random c%0d: got %h exp %h", c, {mem_req, pc_inc, mem_addr, instr_valid, instr}, e_vec);
            end
            advance();
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rstn = 1'b0;
        pc_val = '0;
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = '0;
        instr_ready = 1'b0;
        flush = 1'b0;
        for (int i = 0; i < 32; i++) rom[i] = 8'(i + 16);
        @(negedge clk);
        test_reset();
        test_stream();
        test_stall();
        test_gnt_delay();
        test_flush();
        test_flush_pop_rvalid();
        test_reset_midflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Consumer-side companion to the program counter.
- Takes the current program address, issues in-order read requests to program memory over a req/gnt request channel and an rvalid response channel, and buffers the returned instructions in a 2-entry FIFO.
- Presents instructions to the decoder with a valid/ready handshake.
- Pulses `pc_inc` exactly once per accepted memory request.
- Sits between the PC, program ROM and the decoder.

Parameters:
- ADDR_W, 5, width of program address; must match the PC's SIZE.
- INSTR_W, 8, width of one instruction word.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rstn  input  1  asynchronous active-low reset.
- pc_val  input  ADDR_W  current PC value.
- pc_inc  output  1  advance PC; one-cycle pulse per granted request.
- mem_req  output  1  read request to program memory.
- mem_addr  output  ADDR_W  request address; equals pc_val.
- mem_gnt  input  1  memory accepts the request this cycle.
- mem_rvalid  input  1  read data valid; responses return in request order, at least 1 cycle after gnt.
- mem_rdata  input  INSTR_W  read data.
- instr_valid  output  1  buffer head holds an instruction.
- instr  output  INSTR_W  buffer head instruction.
- instr_ready  input  1  decoder consumes the head this cycle.
- flush  input  1  discard all buffered and in-flight instructions.

Behaviour:
- Reset (async, rstn=0):
  - state=RUN; FIFO empty; outstanding=0; drop_cnt=0.
  - Outputs: mem_req=0, pc_inc=0, instr_valid=0, instr=0.
  - Reset mid-transaction abandons it. Any later rvalid with outstanding=0 is ignored.
- Credits:
  - credits = 2 - (fifo_count + outstanding).
  - Invariant: fifo_count + outstanding <= 2, so the FIFO never overflows.
- Request side (combinational):
  - mem_req = (state==RUN) & (credits>0) & !flush.
  - mem_addr = pc_val.
  - pc_inc = mem_req & mem_gnt, so the PC advances the same edge the request is granted.
  - mem_req stays high until granted; pc_val must not change while waiting.
- Outstanding counter:
  - +1 on grant, -1 on rvalid. Both in the same cycle leaves it unchanged.
  - The counter never goes negative; rvalid with outstanding=0 is ignored.
- Response side:
  - On rvalid with drop_cnt>0: discard data, drop_cnt-1.
  - Otherwise: push mem_rdata into the FIFO tail.
- FIFO:
  - instr_valid = (fifo_count>0); instr = head entry, 0 when empty.
  - Pop on instr_valid & instr_ready.
  - Push and pop in the same cycle keeps the count unchanged; push into an empty FIFO is visible at instr_valid the next cycle (1-cycle rvalid->instr latency).
- FSM, states RUN and DRAIN:
  - RUN -> DRAIN: flush=1 and outstanding net of this cycle's rvalid is >0. drop_cnt <= that value. FIFO cleared.
  - RUN -> RUN on flush with nothing in flight: FIFO cleared only.
  - DRAIN: mem_req=0; rvalid responses are dropped.
  - DRAIN -> RUN when drop_cnt reaches 0.
  - flush in DRAIN has no further effect (FIFO already empty).
- Flush priority:
  - flush overrides a same-cycle pop and push: the FIFO ends empty, and a same-cycle rvalid is consumed as dropped.
  - No grant occurs in a flush cycle because mem_req=0.
- PC reload on a branch is outside this block. The owner reloads the PC while flush is asserted or while in DRAIN.

Test Plan:
- Reset then run with a zero-wait memory: mem_gnt=1, rvalid 1 cycle after gnt, rdata=addr+0x10, instr_ready=1 -> instr stream 0x10,0x11,0x12…; exactly one pc_inc per grant; address wraps 31->0 with instr 0x2F then 0x10.
- Decoder stall: instr_ready=0 -> after 2 grants, mem_req=0, fifo_count=2, pc_inc=0. Raise instr_ready -> mem_req reasserts the cycle after the first pop.
- Memory gnt delay of 3 cycles -> mem_req held high with a stable mem_addr; a single pc_inc in the grant cycle.
- Flush with 2 outstanding and 0 buffered -> state DRAIN, next 2 rvalids dropped (instr_valid stays 0), then RUN and mem_req=1 at the new pc_val.
- Simultaneous flush, pop and rvalid with fifo_count=1, outstanding=1 -> FIFO empty, drop_cnt=0, state RUN, mem_req=1 the next cycle.
- Assert rstn=0 with 1 outstanding, release, then a stray rvalid arrives -> ignored; instr_valid=0, outstanding=0.
